// File: rtl/vrf_port_if.sv
// vrf_port_if: requester-side bus of the VRF port arbiter
// Signals are named from the arbiter's point of view; the slave modport is the arbiter,
// the master modport is the set of requesters. addr_i/wdata_i are packed per requester.
interface vrf_port_if #(
    parameter int NumReq    = 2,
    parameter int VLEN      = 128,
    parameter int AddrWidth = 5
);
    logic [NumReq-1:0]           req_i;
    logic [NumReq-1:0]           we_i;
    logic [NumReq-1:0]           lock_i;
    logic [NumReq*AddrWidth-1:0] addr_i;
    logic [NumReq*VLEN-1:0]      wdata_i;
    logic [NumReq-1:0]           gnt_o;
    logic [NumReq-1:0]           rvalid_o;
    logic [VLEN-1:0]             rdata_o;
    modport master (output req_i, we_i, lock_i, addr_i, wdata_i, input gnt_o, rvalid_o, rdata_o);
    modport slave  (input req_i, we_i, lock_i, addr_i, wdata_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/vrf_port_arbiter.sv
// vrf_port_arbiter: round-robin arbiter with ownership lock for the single-port VRF RAM
// Ports: clk_i/rst_i (sync active-high reset), bus (vrf_port_if.slave: req/we/lock/addr/wdata in,
// gnt/rvalid/rdata out), ram_req_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i to ram_1p,
// perf_grants_o/perf_stall_o counters present only when VRF_ARB_PERF_EN is defined.
module vrf_port_arbiter #(
    parameter int NumReq    = 2,
    parameter int VLEN      = 128,
    parameter int AddrWidth = 5,
    parameter int MaxLock   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    vrf_port_if.slave            bus,
    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [VLEN-1:0]      ram_wdata_o,
    input  logic [VLEN-1:0]      ram_rdata_i,
    output logic [31:0]          perf_grants_o,
    output logic [31:0]          perf_stall_o
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxLock + 1);
    typedef enum logic {ARB_OPEN, ARB_LOCKED} state_e;
    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NumReq-1:0] rd_pend_q;
    logic              any_gnt;
    function automatic logic [IdxW-1:0] rr_add(input logic [IdxW-1:0] p, input int n);
        return IdxW'((int'(p) + n) % NumReq);
    endfunction
    // Scan from the lowest priority to the highest so the last hit is the winner.
    always_comb begin
        gnt_idx = owner_q;
        any_gnt = 1'b0;
        if (state_q == ARB_LOCKED) any_gnt = bus.req_i[owner_q];
        else
            for (int i = NumReq - 1; i >= 0; i--)
                if (bus.req_i[rr_add(rr_ptr_q, i)]) begin
                    gnt_idx = rr_add(rr_ptr_q, i);
                    any_gnt = 1'b1;
                end
        if (rst_i) any_gnt = 1'b0;
    end
    // The lock counter includes the grant cycle, so ownership never exceeds MaxLock cycles
    // and MaxLock = 1 never leaves ARB_OPEN.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q == ARB_OPEN) begin
            if (any_gnt) begin
                rr_ptr_d = rr_add(gnt_idx, 1);
                if (bus.lock_i[gnt_idx] && MaxLock > 1) begin
                    state_d    = ARB_LOCKED;
                    owner_d    = gnt_idx;
                    lock_cnt_d = CntW'(1);
                end
            end
        end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            if (!bus.lock_i[owner_q] || lock_cnt_d == CntW'(MaxLock)) begin
                state_d    = ARB_OPEN;
                rr_ptr_d   = rr_add(owner_q, 1);
                lock_cnt_d = '0;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_OPEN;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            rd_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= bus.gnt_o & ~bus.we_i;
        end
    end
    assign bus.gnt_o    = any_gnt ? NumReq'(1) << gnt_idx : '0;
    assign bus.rvalid_o = rst_i ? '0 : rd_pend_q;
    assign bus.rdata_o  = rst_i ? '0 : ram_rdata_i;
    assign ram_req_o    = any_gnt;
    assign ram_we_o     = any_gnt & bus.we_i[gnt_idx];
    assign ram_addr_o   = any_gnt ? bus.addr_i[gnt_idx*AddrWidth +: AddrWidth] : '0;
    assign ram_wdata_o  = any_gnt ? bus.wdata_i[gnt_idx*VLEN +: VLEN] : '0;
`ifdef VRF_ARB_PERF_EN
    logic [31:0] perf_grants_q, perf_stall_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grants_q <= perf_grants_q + 32'(any_gnt);
            perf_stall_q  <= perf_stall_q + 32'(|(bus.req_i & ~bus.gnt_o));
        end
    end
    assign perf_grants_o = perf_grants_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_grants_o = '0;
    assign perf_stall_o  = '0;
`endif
endmodule

// File: tb/tb_vrf_port_arbiter.sv
// tb_vrf_port_arbiter: directed self-checking bench for vrf_port_arbiter with a 1-cycle RAM model
module tb_vrf_port_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ram_req, ram_we;
    logic [4:0]   ram_addr;
    logic [127:0] ram_wdata, ram_rdata;
    logic [31:0]  perf_grants, perf_stall;
    logic [127:0] mem [32];
    int           passed = 0;
    int           total  = 0;
    vrf_port_if #(.NumReq(2), .VLEN(128), .AddrWidth(5)) vif ();
    vrf_port_arbiter #(.NumReq(2), .VLEN(128), .AddrWidth(5), .MaxLock(4)) dut (
        .clk_i(clk), .rst_i(rst), .bus(vif),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .perf_grants_o(perf_grants), .perf_stall_o(perf_stall)
    );
    always #5 clk = ~clk;
    function automatic logic [127:0] pre(input int a);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(a);
        return {4{w}};
    endfunction
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 32; i++) mem[i] <= pre(i);
        else if (ram_req && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_req) ram_rdata <= mem[ram_addr];
    end
    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [127:0] d0);
        @(negedge clk);
        vif.req_i   = r;
        vif.we_i    = w;
        vif.lock_i  = l;
        vif.addr_i  = {a1, a0};
        vif.wdata_i = {128'h0, d0};
        #1;
    endtask
    task automatic chk_gnt(input string n, input logic [1:0] e);
        total++;
        if (vif.gnt_o !== e) $display("FAIL %s gnt: got %b want %b", n, vif.gnt_o, e); else passed++;
    endtask
    task automatic chk_rd(input string n, input logic [1:0] ev, input logic [127:0] ed, input logic use_d);
        total++;
        if (vif.rvalid_o !== ev) $display("FAIL %s rvalid: got %b want %b", n, vif.rvalid_o, ev); else passed++;
        if (use_d) begin
            total++;
            if (vif.rdata_o !== ed) $display("FAIL %s rdata: got %h want %h", n, vif.rdata_o, ed); else passed++;
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0);
            chk_gnt("reset", 2'b00);
            chk_rd("reset", 2'b00, '0, 1'b1);
            total++;
            if (ram_req !== 1'b0 || ram_addr !== 5'd0 || ram_wdata !== '0)
                $display("FAIL reset_ram: got req=%b addr=%0d wdata=%h want 0", ram_req, ram_addr, ram_wdata);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_gnt("reset_release", 2'b01);
        vif.req_i = 2'b00;
        #1;
    endtask
    task automatic test_round_robin();
        drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0);
        chk_gnt("rr1", 2'b01);
        chk_rd("rr1", 2'b00, '0, 1'b0);
        total++;
        if (ram_addr !== 5'd1) $display("FAIL rr1_addr: got %0d want 1", ram_addr); else passed++;
        drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0);
        chk_gnt("rr2", 2'b10);
        chk_rd("rr2", 2'b01, pre(1), 1'b1);
        drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0);
        chk_gnt("rr3", 2'b01);
        chk_rd("rr3", 2'b10, pre(2), 1'b1);
        drive(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, '0);
        chk_gnt("rr4", 2'b10);
        chk_rd("rr4", 2'b01, pre(1), 1'b1);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
        chk_gnt("rr_idle", 2'b00);
        chk_rd("rr_idle", 2'b10, pre(2), 1'b1);
    endtask
    task automatic test_lock();
        logic [127:0] w;
        w = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        drive(2'b11, 2'b00, 2'b01, 5'd3, 5'd10, '0);
        chk_gnt("lock1", 2'b01);
        drive(2'b11, 2'b00, 2'b01, 5'd4, 5'd10, '0);
        chk_gnt("lock2", 2'b01);
        chk_rd("lock2", 2'b01, pre(3), 1'b1);
        drive(2'b11, 2'b01, 2'b00, 5'd5, 5'd10, w);
        chk_gnt("lock3", 2'b01);
        chk_rd("lock3", 2'b01, pre(4), 1'b1);
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 5'd5 || ram_wdata !== w)
            $display("FAIL lock3_write: got we=%b addr=%0d wdata=%h want 1/5/%h", ram_we, ram_addr, ram_wdata, w);
        else passed++;
        drive(2'b10, 2'b00, 2'b00, 5'd5, 5'd10, '0);
        chk_gnt("lock4", 2'b10);
        chk_rd("lock4_after_write", 2'b00, '0, 1'b0);
        drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd10, '0);
        chk_gnt("lock_rb", 2'b01);
        chk_rd("lock_r1_data", 2'b10, pre(10), 1'b1);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
        chk_rd("lock_readback", 2'b01, w, 1'b1);
    endtask
    task automatic test_lock_timeout();
        int  c;
        logic hit;
        c   = 0;
        hit = 1'b0;
        while (!hit && c < 10) begin
            drive(2'b11, 2'b00, 2'b10, 5'd0, 5'd6, '0);
            if (c == 0) chk_gnt("timeout_first", 2'b10);
            if (vif.gnt_o[0]) hit = 1'b1;
            else c++;
        end
        total++;
        if (!hit || c != 4) $display("FAIL lock_timeout: req0 granted after %0d cycles (hit=%b) want 4", c, hit);
        else passed++;
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
    endtask
    task automatic test_back_to_back();
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd7, '0);
        chk_gnt("pipe1", 2'b10);
        chk_rd("pipe1", 2'b00, '0, 1'b0);
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd8, '0);
        chk_gnt("pipe2", 2'b10);
        chk_rd("pipe2", 2'b10, pre(7), 1'b1);
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd9, '0);
        chk_rd("pipe3", 2'b10, pre(8), 1'b1);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
        chk_rd("pipe4", 2'b10, pre(9), 1'b1);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
        chk_rd("pipe5", 2'b00, '0, 1'b0);
    endtask
    task automatic test_perf();
        logic [31:0] e;
`ifdef VRF_ARB_PERF_EN
        e = 32'd10;
`else
        e = 32'd0;
`endif
        drive(2'b01, 2'b00, 2'b00, 5'd1, 5'd0, '0);
        chk_gnt("pre_reset_read", 2'b01);
        @(negedge clk);
        rst = 1'b1;
        vif.req_i = 2'b00;
        #1;
        chk_rd("rst_kill_read", 2'b00, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rd("post_rst", 2'b00, '0, 1'b0);
        total++;
        if (perf_grants !== 32'd0 || perf_stall !== 32'd0)
            $display("FAIL perf_clear: got %0d/%0d want 0/0", perf_grants, perf_stall);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            drive(2'b11, 2'b00, 2'b00, 5'd2, 5'd3, '0);
            if (c == 0) chk_gnt("perf_first", 2'b01);
        end
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, '0);
        total++;
        if (perf_grants !== e) $display("FAIL perf_grants: got %0d want %0d", perf_grants, e); else passed++;
        total++;
        if (perf_stall !== e) $display("FAIL perf_stall: got %0d want %0d", perf_stall, e); else passed++;
    endtask
    initial begin
        vif.req_i   = '0;
        vif.we_i    = '0;
        vif.lock_i  = '0;
        vif.addr_i  = '0;
        vif.wdata_i = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_back_to_back();
        test_perf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
